// File: rtl/data_mem_responder.sv
// Word-organised data memory with a fixed-latency request/response handshake.
// Supports word and zero-extended byte accesses with range and alignment fault reporting.
module data_mem_responder #(
  parameter int ADDR_WORDS_LOG2 = 8,
  parameter int LATENCY         = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic        byte_acc,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int WORDS = 1 << ADDR_WORDS_LOG2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  logic        we_reg;
  logic        byte_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic        ready_reg;
  logic        err_reg;
  logic [31:0] rdata_reg;

  logic [31:0] mem [WORDS];
  logic [31:0] rd_word_reg;

  logic [ADDR_WORDS_LOG2-1:0] idx;
  logic [1:0]  lane;
  logic        range_fault;
  logic        align_fault;
  logic        fault;
  logic        store_en;
  logic [3:0]  be;
  logic [31:0] wr_word;
  logic [31:0] rd_shift;

  assign idx         = addr_reg[ADDR_WORDS_LOG2+1:2];
  assign lane        = addr_reg[1:0];
  assign range_fault = |addr_reg[31:ADDR_WORDS_LOG2+2];
  assign align_fault = !byte_reg && (addr_reg[1:0] != 2'b00);
  assign fault       = range_fault || align_fault;
  assign store_en    = (state_reg == RESP) && we_reg && !fault;
  assign rd_shift    = rd_word_reg >> {27'd0, lane, 3'b000};

  // Byte stores replicate the low byte onto the selected lane only.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign be[gi]             = !byte_reg || (lane == 2'(gi));
      assign wr_word[gi*8 +: 8] = byte_reg ? wdata_reg[7:0] : wdata_reg[gi*8 +: 8];
    end
  endgenerate

  // Storage is never reset; the captured index is stable from the accept edge,
  // so the registered read is settled well before RESP.
  always_ff @(posedge clk) begin
    if (store_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][i*8 +: 8] <= wr_word[i*8 +: 8];
      end
    end
    rd_word_reg <= mem[idx];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      we_reg    <= 1'b0;
      byte_reg  <= 1'b0;
      addr_reg  <= 32'd0;
      wdata_reg <= 32'd0;
      ready_reg <= 1'b0;
      err_reg   <= 1'b0;
      rdata_reg <= 32'd0;
    end else begin
      ready_reg <= 1'b0;
      err_reg   <= 1'b0;
      rdata_reg <= 32'd0;
      case (state_reg)
        IDLE: begin
          if (req) begin
            we_reg    <= we;
            byte_reg  <= byte_acc;
            addr_reg  <= addr;
            wdata_reg <= wdata;
            cnt_reg   <= 4'(LATENCY - 1);
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_reg == 4'd0) begin
            state_reg <= RESP;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        RESP: begin
          // Response flops load here, so the strobe follows one edge later.
          ready_reg <= 1'b1;
          if (fault) begin
            err_reg <= 1'b1;
          end else if (!we_reg) begin
            rdata_reg <= byte_reg ? {24'd0, rd_shift[7:0]} : rd_word_reg;
          end
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ready = ready_reg;
  assign err   = err_reg;
  assign rdata = rdata_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: handshake timing, byte lanes, faults,
// reset abort and back-to-back held requests, at LATENCY 2 and LATENCY 1.
module tb_data_mem_responder;

  logic        clk;
  logic        reset;
  logic        req, we, byte_acc;
  logic [31:0] addr, wdata;
  logic        ready;
  logic [31:0] rdata;
  logic        err;
  logic        req1, we1, byte_acc1;
  logic [31:0] addr1, wdata1;
  logic        ready1;
  logic [31:0] rdata1;
  logic        err1;

  int n_checks = 0;
  int n_fail   = 0;

  data_mem_responder #(.ADDR_WORDS_LOG2(8), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .byte_acc(byte_acc),
    .addr(addr), .wdata(wdata), .ready(ready), .rdata(rdata), .err(err)
  );

  data_mem_responder #(.ADDR_WORDS_LOG2(8), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .req(req1), .we(we1), .byte_acc(byte_acc1),
    .addr(addr1), .wdata(wdata1), .ready(ready1), .rdata(rdata1), .err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // One access: accept at the first edge, then count edges until ready.
  task automatic access(input bit sel, input logic w, input logic b,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int n);
    @(negedge clk);
    if (sel) begin req1 = 1'b1; we1 = w; byte_acc1 = b; addr1 = a; wdata1 = d; end
    else     begin req  = 1'b1; we  = w; byte_acc  = b; addr  = a; wdata  = d; end
    @(posedge clk); #1;
    n = 99; rd = 32'hx; er = 1'bx;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (sel ? ready1 : ready) begin
        n  = k;
        rd = sel ? rdata1 : rdata;
        er = sel ? err1 : err;
        break;
      end
    end
    if (sel) req1 = 1'b0; else req = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          n;
  logic [31:0] mask;
  int          good;
  int          hits;

  initial begin
    reset = 1'b1;
    req = 0; we = 0; byte_acc = 0; addr = 0; wdata = 0;
    req1 = 0; we1 = 0; byte_acc1 = 0; addr1 = 0; wdata1 = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_err",   {31'd0, err},   32'd0);
    check("reset_rdata", rdata,          32'd0);
    @(negedge clk);
    reset = 1'b0;

    // word store then load
    access(0, 1, 0, 32'h10, 32'hDEADBEEF, rd, er, n);
    check("st10_latency", n, 3);
    check("st10_err",     {31'd0, er}, 32'd0);
    check("st10_rdata",   rd, 32'd0);
    access(0, 0, 0, 32'h10, 32'h0, rd, er, n);
    check("ld10_latency", n, 3);
    check("ld10_rdata",   rd, 32'hDEADBEEF);
    check("ld10_err",     {31'd0, er}, 32'd0);

    // byte lanes
    access(0, 1, 0, 32'h20, 32'h11223344, rd, er, n);
    access(0, 1, 1, 32'h22, 32'h123456AA, rd, er, n);
    check("stb22_err", {31'd0, er}, 32'd0);
    access(0, 0, 0, 32'h20, 32'h0, rd, er, n);
    check("ld20_rdata", rd, 32'h11AA3344);
    access(0, 0, 1, 32'h23, 32'h0, rd, er, n);
    check("ldb23_rdata", rd, 32'h00000011);
    access(0, 0, 1, 32'h21, 32'h0, rd, er, n);
    check("ldb21_rdata", rd, 32'h00000033);
    check("ldb21_err",   {31'd0, er}, 32'd0);

    // faults
    access(0, 0, 0, 32'h21, 32'h0, rd, er, n);
    check("ld21_align_err",   {31'd0, er}, 32'd1);
    check("ld21_align_rdata", rd, 32'd0);
    access(0, 1, 0, 32'h0, 32'h55AA1234, rd, er, n);
    access(0, 1, 0, 32'h400, 32'hFFFFFFFF, rd, er, n);
    check("st400_range_err", {31'd0, er}, 32'd1);
    check("st400_latency",   n, 3);
    access(0, 0, 0, 32'h0, 32'h0, rd, er, n);
    check("ld0_unchanged", rd, 32'h55AA1234);

    // reset during WAIT aborts the store
    access(0, 1, 0, 32'h30, 32'h12345678, rd, er, n);
    @(negedge clk);
    req = 1'b1; we = 1'b1; byte_acc = 1'b0; addr = 32'h30; wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("rst_mid_rdata", rdata, 32'd0);
    hits = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (ready) hits++;
    end
    check("rst_abort_ready", hits, 0);
    @(negedge clk);
    reset = 1'b0;
    access(0, 0, 0, 32'h30, 32'h0, rd, er, n);
    check("ld30_prior", rd, 32'h12345678);

    // held req: three loads, ready edges 3, 7, 11 after the first accept
    @(negedge clk);
    req = 1'b1; we = 1'b0; byte_acc = 1'b0; addr = 32'h10; wdata = 32'h0;
    mask = 32'd0; good = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (ready) begin
        mask[i] = 1'b1;
        if (rdata == 32'hDEADBEEF) good++;
      end
      if (i == 11) req = 1'b0;
    end
    check("held_ready_mask", mask, 32'h00000888);
    check("held_data",       good, 3);
    hits = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (ready) hits++;
    end
    check("held_no_extra", hits, 0);

    // LATENCY=1 instance
    access(1, 1, 0, 32'h44, 32'hA5A5C3C3, rd, er, n);
    check("l1_st_latency", n, 2);
    access(1, 0, 0, 32'h44, 32'h0, rd, er, n);
    check("l1_ld_latency", n, 2);
    check("l1_ld_rdata",   rd, 32'hA5A5C3C3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
